// File: rtl/clk_gen_pkg.sv
// Shared state encoding and configuration clamp for the clock-enable generator.
package clk_gen_pkg;

    typedef enum logic [1:0] {
        SETTLE,
        LOCKED,
        PENDING
    } state_e;

    localparam int MIN_DIV = 2;

    typedef struct packed {
        logic [31:0] div;
        logic [31:0] phase;
    } cfg_t;

    // Phase is clamped against the already-clamped divisor.
    function automatic cfg_t clamp_cfg(input logic [31:0] div, input logic [31:0] phase);
        cfg_t c;
        c.div   = (div < MIN_DIV) ? 32'(MIN_DIV) : div;
        c.phase = (phase >= c.div) ? c.div - 32'd1 : phase;
        return c;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: free-running counter with tick pulse and square-wave output.
module clk_div_channel
    import clk_gen_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 50
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic [DIV_W-1:0] phase_i,
    output logic             wrap_o,
    output logic             tick_o,
    output logic             outclk_o
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] phase_q, phase_d;
    logic             tick_q;
    logic             outclk_q;

    assign wrap_o = en_i && (cnt_q == div_q - ONE);

    // A load only arrives on a wrap or while disabled, so it always restarts from phase.
    always_comb begin
        div_d   = load_i ? div_i : div_q;
        phase_d = load_i ? phase_i : phase_q;
        if (load_i || !en_i) begin
            cnt_d = phase_d;
        end else if (wrap_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            div_q    <= DIV_W'(DEFAULT_DIV);
            phase_q  <= '0;
            tick_q   <= 1'b0;
            outclk_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            phase_q  <= phase_d;
            tick_q   <= wrap_o;
            outclk_q <= en_i && (cnt_d < (div_d >> 1));
        end
    end

    assign tick_o   = tick_q;
    assign outclk_o = outclk_q;

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator with runtime reconfiguration and lock tracking.
module clk_enable_gen
    import clk_gen_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 50,
    parameter int LOCK_CYCLES = 16,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk_i,
    input  logic              rst_i,
    input  logic [NUM_CH-1:0] ch_en_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [DIV_W-1:0]  cfg_div_i,
    input  logic [DIV_W-1:0]  cfg_phase_i,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] outclk_o,
    output logic              locked_o
);

    localparam int SET_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(LOCK_CYCLES - 1);

    state_e             state_q;
    logic [SET_W-1:0]   settle_q;
    logic               locked_q;
    logic               ready_q;
    logic               pend_vld_q;
    logic [CH_W-1:0]    pend_ch_q;
    logic [DIV_W-1:0]   pend_div_q;
    logic [DIV_W-1:0]   pend_phase_q;

    cfg_t               cfg_c;
    logic               unused_cfg;
    logic [NUM_CH-1:0]  acc_hit, pend_hit, wrap, load;
    logic               accept, acc_ok, pend_ok, apply, pend_done;

    assign cfg_c      = clamp_cfg(32'(cfg_div_i), 32'(cfg_phase_i));
    assign unused_cfg = ^cfg_c;

    // Channel decode is per-instance so an out-of-range id simply matches nothing.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign acc_hit[i]  = (cfg_ch_i == CH_W'(i));
        assign pend_hit[i] = (pend_ch_q == CH_W'(i));
        assign load[i]     = pend_vld_q && pend_hit[i] && (wrap[i] || !ch_en_i[i]);

        clk_div_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk_i    (refclk_i),
            .rst_i    (rst_i),
            .en_i     (ch_en_i[i]),
            .load_i   (load[i]),
            .div_i    (pend_div_q),
            .phase_i  (pend_phase_q),
            .wrap_o   (wrap[i]),
            .tick_o   (tick_o[i]),
            .outclk_o (outclk_o[i])
        );
    end

    assign accept    = cfg_valid_i && ready_q;
    assign acc_ok    = |acc_hit;
    assign pend_ok   = |pend_hit;
    assign apply     = |load;
    assign pend_done = apply || !pend_ok;

    always_ff @(posedge refclk_i) begin
        if (rst_i) begin
            state_q      <= SETTLE;
            settle_q     <= '0;
            locked_q     <= 1'b0;
            ready_q      <= 1'b0;
            pend_vld_q   <= 1'b0;
            pend_ch_q    <= '0;
            pend_div_q   <= '0;
            pend_phase_q <= '0;
        end else begin
            if (accept) begin
                pend_vld_q   <= 1'b1;
                pend_ch_q    <= cfg_ch_i;
                pend_div_q   <= DIV_W'(cfg_c.div);
                pend_phase_q <= DIV_W'(cfg_c.phase);
            end else if (pend_vld_q && pend_done) begin
                pend_vld_q <= 1'b0;
            end
            ready_q <= !accept && !(pend_vld_q && !pend_done);

            case (state_q)
                SETTLE: begin
                    if (accept && acc_ok) begin
                        state_q  <= PENDING;
                        locked_q <= 1'b0;
                    end else if (settle_q == SETTLE_LAST) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                    end else begin
                        settle_q <= settle_q + SET_W'(1);
                    end
                end
                LOCKED: begin
                    if (accept && acc_ok) begin
                        state_q  <= PENDING;
                        locked_q <= 1'b0;
                    end
                end
                PENDING: begin
                    locked_q <= 1'b0;
                    if (apply) begin
                        state_q  <= SETTLE;
                        settle_q <= '0;
                    end
                end
                default: begin
                    state_q  <= SETTLE;
                    settle_q <= '0;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready_o = ready_q;
    assign locked_o    = locked_q;

endmodule
